// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF       = 16;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned MAX_LOCK_DEF = 4;
    localparam int unsigned CNT_W        = 4;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LDR = 1;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_e;

    function automatic owner_e other_port(input owner_e o);
        return (o == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Two-way round-robin arbiter with a bounded lock extension for bursts.
module rr_lock_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    owner_e           last_owner_q, last_owner_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic [1:0] req_v;
    logic       contested;
    logic       any_req;
    owner_e     win;

    // Grant decision and next-state for ownership, lock flag and lock counter
    always_comb begin
        req_v        = rst ? 2'b00 : req;
        contested    = &req_v;
        any_req      = |req_v;
        win          = last_owner_q;
        gnt          = 2'b00;
        last_owner_d = last_owner_q;
        locked_d     = 1'b0;
        lock_cnt_d   = lock_cnt_q;

        if (req_v == 2'b01) begin
            win = OWNER_CPU;
        end else if (req_v == 2'b10) begin
            win = OWNER_LDR;
        end else if (contested) begin
            if (locked_q && (lock_cnt_q < CNT_W'(MAX_LOCK))) begin
                win = last_owner_q;
            end else begin
                win = other_port(last_owner_q);
            end
        end

        if (any_req) begin
            gnt          = (win == OWNER_LDR) ? 2'b10 : 2'b01;
            last_owner_d = win;
            locked_d     = (win == OWNER_LDR) ? lock[1] : lock[0];
            // Only contested re-grants count toward the lock bound
            if (contested && (win == last_owner_q)) begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWNER_LDR;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (port 0)
// and the loader/debug port (port 1); registers read data back per port.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0] gnt;

    logic          p0_rvalid_q, p0_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;

    rr_lock_arbiter #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({p1_req, p0_req}),
        .lock ({p1_lock, p0_lock}),
        .gnt  (gnt)
    );

    assign p0_gnt = gnt[1'(PORT_CPU)];
    assign p1_gnt = gnt[1'(PORT_LDR)];

    // Memory-side mux: idle bus is driven to all zeros
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_read  = ~p0_we;
            mem_write = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_read  = ~p1_we;
            mem_write = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    // Read return: capture memory data at the grant edge, hold it otherwise
    always_comb begin
        p0_rvalid_d = p0_gnt & ~p0_we;
        p1_rvalid_d = p1_gnt & ~p1_we;
        p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed cycles push expected grants
// and read returns; a negedge monitor pops and compares what the DUT presents.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_lock;
    logic [15:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic [15:0] p0_rdata;
    logic        p1_req, p1_we, p1_lock;
    logic [15:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [15:0] p1_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Simple memory model with a preload on its first clock
    logic [15:0] mem [256];
    bit          mem_ready = 1'b0;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[0]    <= 16'h0005;
            mem[1]    <= 16'h0A01;
            mem[2]    <= 16'h0B02;
            mem[3]    <= 16'h0C03;
            mem[4]    <= 16'h0D04;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } gnt_t;
    typedef struct {
        int          port;
        logic [15:0] data;
    } rv_t;

    gnt_t gq[$];
    rv_t  rq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; ep = expected granted port (-1 none), erd = expected read data
    task automatic cyc(input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1,
                       input int ep, input logic [15:0] erd);
        gnt_t g;
        rv_t  r;
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
        if (ep == 0) begin
            g = '{0, ~w0, w0, a0, d0};
            gq.push_back(g);
            if (!w0) begin r = '{0, erd}; rq.push_back(r); end
        end else if (ep == 1) begin
            g = '{1, ~w1, w1, a1, d1};
            gq.push_back(g);
            if (!w1) begin r = '{1, erd}; rq.push_back(r); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, -1, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever a grant or read return is presented
    always @(negedge clk) begin
        if (started) begin
            gnt_t g;
            rv_t  r;
            if (p0_gnt && p1_gnt) begin
                chk("gnt_onehot", 1'b0, 64'({p1_gnt, p0_gnt}), 64'h1);
            end else if (p0_gnt || p1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 1'b0, 64'({p1_gnt, p0_gnt}), 64'h0);
                end else begin
                    logic [63:0] act, exp;
                    g   = gq.pop_front();
                    act = {2'(p1_gnt ? 1 : 0), mem_read, mem_write, mem_addr, mem_wdata};
                    exp = {2'(g.port), g.rd, g.wr, g.addr, g.wdata};
                    chk("grant", act == exp, act, exp);
                end
            end else begin
                chk("idle_bus", {mem_read, mem_write, mem_addr, mem_wdata} == 34'h0,
                    64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'h0);
            end

            if (p0_rvalid && p1_rvalid) begin
                chk("rvalid_onehot", 1'b0, 64'({p1_rvalid, p0_rvalid}), 64'h1);
            end else if (p0_rvalid || p1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 1'b0, 64'({p1_rvalid, p0_rvalid}), 64'h0);
                end else begin
                    logic [63:0] act, exp;
                    r   = rq.pop_front();
                    act = p0_rvalid ? {32'd0, 16'd0, p0_rdata} : {32'd1, 16'd0, p1_rdata};
                    exp = {32'(r.port), 16'd0, r.data};
                    chk("read_return", act == exp, act, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int lock_seq [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        chk("rst_gnt", {p0_gnt, p1_gnt} == 2'b00, 64'({p0_gnt, p1_gnt}), 64'h0);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid} == 2'b00, 64'({p0_rvalid, p1_rvalid}), 64'h0);
        chk("rst_rdata", {p0_rdata, p1_rdata} == 32'h0, 64'({p0_rdata, p1_rdata}), 64'h0);
        chk("rst_lock_cnt", dut.u_arb.lock_cnt_q == 4'd0, 64'(dut.u_arb.lock_cnt_q), 64'h0);

        // p0 read of address 0 right after reset
        cyc(1, 0, 0, 16'd0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0005);
        chk("p1_quiet", {p1_rvalid, p1_rdata} == 17'h0, 64'({p1_rvalid, p1_rdata}), 64'h0);
        idle();

        // p1 write 20 <- 15, then p0 reads it back
        cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'd20, 16'd15, 1, 16'h0);
        cyc(1, 0, 0, 16'd20, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'd15);
        idle();

        // Same-address read/write contention: p1 wins the tie, p0 sees new data
        cyc(1, 0, 0, 16'd30, 16'h0, 1, 1, 0, 16'd30, 16'h0077, 1, 16'h0);
        cyc(1, 0, 0, 16'd30, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0077);
        idle();

        // Unlocked contention alternates starting with p0
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 16'd1, 16'h0, 1, 0, 0, 16'd2, 16'h0, i % 2,
                (i % 2 == 0) ? 16'h0A01 : 16'h0B02);
        idle();

        // p0 lock burst bounded at initial + MAX_LOCK grants, then alternation
        do_reset();
        for (int i = 0; i < 9; i++)
            cyc(1, 0, (i < 5) ? 1'b1 : 1'b0, 16'd3, 16'h0, 1, 0, 0, 16'd4, 16'h0,
                lock_seq[i], (lock_seq[i] == 0) ? 16'h0C03 : 16'h0D04);
        idle();

        // Uncontested lock never counts
        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'd4, 16'h0, 1, 16'h0D04);
        chk("lock_cnt_uncontested", dut.u_arb.lock_cnt_q == 4'd0, 64'(dut.u_arb.lock_cnt_q), 64'h0);
        idle();

        // Reset after a read grant clears return state and drops the pending write
        do_reset();
        cyc(1, 0, 0, 16'd0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0005);
        rst = 1'b1;
        cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'd0, 16'h0099, -1, 16'h0);
        rst = 1'b0;
        chk("rst_mid_rvalid", p0_rvalid == 1'b0, 64'(p0_rvalid), 64'h0);
        chk("rst_mid_rdata", p0_rdata == 16'h0, 64'(p0_rdata), 64'h0);
        cyc(1, 0, 0, 16'd0, 16'h0, 1, 0, 0, 16'd2, 16'h0, 0, 16'h0005);
        cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'd2, 16'h0, 1, 16'h0B02);
        idle();
        idle();

        chk("grant_queue_drained", gq.size() == 0, 64'(gq.size()), 64'h0);
        chk("read_queue_drained", rq.size() == 0, 64'(rq.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
